// File: rtl/smg_595_rx.sv
// smg_595_rx: receiver/decoder for the 3-wire 74HC595 seven-segment serial link.
//   clk, rst_n          : system clock, asynchronous active-low reset
//   ds_data/shcp/stcp   : asynchronous serial data, shift clock, latch clock
//   frame, frame_vld    : last latched raw frame (first bit at [15]) and its 1-clk strobe
//   dig_no, dig_val     : digit index and hex value of the last good frame
//   len_err/seg_err/sel_err : per-frame status, valid with frame_vld, held until next latch
//   disp_data, dig_seen : rebuilt display word (digit k at [4k+3:4k]) and sticky seen mask
module smg_595_rx #(
  parameter int SYNC_STAGES = 2,
  parameter int FRAME_BITS  = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ds_data,
  input  logic        ds_shcp,
  input  logic        ds_stcp,
  output logic [15:0] frame,
  output logic        frame_vld,
  output logic [1:0]  dig_no,
  output logic [3:0]  dig_val,
  output logic        len_err,
  output logic        seg_err,
  output logic        sel_err,
  output logic [15:0] disp_data,
  output logic [3:0]  dig_seen
);
  localparam logic [4:0] LP_FRAME = 5'(FRAME_BITS);
  logic [SYNC_STAGES-1:0] r_sync_d, r_sync_sh, r_sync_st;
  logic        r_hist_sh, r_hist_st;
  logic [15:0] r_shreg, r_frame, r_disp;
  logic [4:0]  r_cnt;
  logic        r_vld, r_len, r_seg, r_sel;
  logic [1:0]  r_no;
  logic [3:0]  r_val, r_seen;
  logic        w_sh_rise, w_st_rise, w_seg_ok, w_sel_ok, w_len_bad;
  logic [3:0]  w_seg_val;
  logic [1:0]  w_sel_no;
  assign w_sh_rise = r_sync_sh[SYNC_STAGES-1] & ~r_hist_sh;
  assign w_st_rise = r_sync_st[SYNC_STAGES-1] & ~r_hist_st;
  // length is judged on the count before any shift landing in the same clk
  assign w_len_bad = r_cnt != LP_FRAME;
  // decode works on the pre-shift register, which is exactly what gets latched
  always_comb begin
    w_seg_ok  = 1'b1;
    w_seg_val = 4'h0;
    case (r_shreg[15:8])
      8'hC0: w_seg_val = 4'h0;
      8'hF9: w_seg_val = 4'h1;
      8'hA4: w_seg_val = 4'h2;
      8'hB0: w_seg_val = 4'h3;
      8'h99: w_seg_val = 4'h4;
      8'h92: w_seg_val = 4'h5;
      8'h82: w_seg_val = 4'h6;
      8'hF8: w_seg_val = 4'h7;
      8'h80: w_seg_val = 4'h8;
      8'h90: w_seg_val = 4'h9;
      8'h88: w_seg_val = 4'hA;
      8'h83: w_seg_val = 4'hB;
      8'hC6: w_seg_val = 4'hC;
      8'hA1: w_seg_val = 4'hD;
      8'h86: w_seg_val = 4'hE;
      8'h8E: w_seg_val = 4'hF;
      default: w_seg_ok = 1'b0;
    endcase
  end
  always_comb begin
    w_sel_ok = 1'b1;
    w_sel_no = 2'd0;
    case (r_shreg[7:0])
      8'hFE: w_sel_no = 2'd0;
      8'hFD: w_sel_no = 2'd1;
      8'hFB: w_sel_no = 2'd2;
      8'hF7: w_sel_no = 2'd3;
      default: w_sel_ok = 1'b0;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync_d  <= '0;
      r_sync_sh <= '0;
      r_sync_st <= '0;
      r_hist_sh <= 1'b0;
      r_hist_st <= 1'b0;
      r_shreg   <= '0;
      r_cnt     <= '0;
      r_frame   <= '0;
      r_vld     <= 1'b0;
      r_len     <= 1'b0;
      r_seg     <= 1'b0;
      r_sel     <= 1'b0;
      r_no      <= '0;
      r_val     <= '0;
      r_disp    <= '0;
      r_seen    <= '0;
    end else begin
      r_sync_d  <= {r_sync_d[SYNC_STAGES-2:0], ds_data};
      r_sync_sh <= {r_sync_sh[SYNC_STAGES-2:0], ds_shcp};
      r_sync_st <= {r_sync_st[SYNC_STAGES-2:0], ds_stcp};
      r_hist_sh <= r_sync_sh[SYNC_STAGES-1];
      r_hist_st <= r_sync_st[SYNC_STAGES-1];
      r_vld     <= w_st_rise;
      if (w_sh_rise)
        r_shreg <= {r_shreg[14:0], r_sync_d[SYNC_STAGES-1]};
      if (w_st_rise)
        r_cnt <= {4'd0, w_sh_rise};
      else if (w_sh_rise && r_cnt != 5'd31)
        r_cnt <= r_cnt + 5'd1;
      if (w_st_rise) begin
        r_frame <= r_shreg;
        r_len   <= w_len_bad;
        r_seg   <= ~w_seg_ok;
        r_sel   <= ~w_sel_ok;
        if (!w_len_bad && w_seg_ok && w_sel_ok) begin
          r_no                   <= w_sel_no;
          r_val                  <= w_seg_val;
          r_disp[w_sel_no*4 +: 4] <= w_seg_val;
          r_seen[w_sel_no]       <= 1'b1;
        end
      end
    end
  end
  assign frame     = r_frame;
  assign frame_vld = r_vld;
  assign dig_no    = r_no;
  assign dig_val   = r_val;
  assign len_err   = r_len;
  assign seg_err   = r_seg;
  assign sel_err   = r_sel;
  assign disp_data = r_disp;
  assign dig_seen  = r_seen;
endmodule

// File: tb/tb_smg_595_rx.sv
// tb_smg_595_rx: scoreboard bench for smg_595_rx with directed link frames.
module tb_smg_595_rx;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ds_data = 1'b0, ds_shcp = 1'b0, ds_stcp = 1'b0;
  logic [15:0] frame, disp_data;
  logic        frame_vld, len_err, seg_err, sel_err;
  logic [1:0]  dig_no;
  logic [3:0]  dig_val, dig_seen;
  typedef struct packed {
    logic [15:0] frame;
    logic        len, seg, sel;
    logic [1:0]  no;
    logic [3:0]  val;
    logic [15:0] disp;
    logic [3:0]  seen;
  } exp_t;
  exp_t q[$];
  int n_chk = 0, n_fail = 0, n_vld = 0;
  smg_595_rx dut (
    .clk(clk), .rst_n(rst_n), .ds_data(ds_data), .ds_shcp(ds_shcp), .ds_stcp(ds_stcp),
    .frame(frame), .frame_vld(frame_vld), .dig_no(dig_no), .dig_val(dig_val),
    .len_err(len_err), .seg_err(seg_err), .sel_err(sel_err),
    .disp_data(disp_data), .dig_seen(dig_seen)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, a, e);
    end
  endtask
  always @(negedge clk) begin
    if (frame_vld) begin
      exp_t e;
      n_vld++;
      if (q.size() == 0) chk("unexpected_frame_vld", {16'd0, frame}, 32'hFFFF_FFFF);
      else begin
        e = q.pop_front();
        chk("frame", {16'd0, frame}, {16'd0, e.frame});
        chk("errs", {29'd0, len_err, seg_err, sel_err}, {29'd0, e.len, e.seg, e.sel});
        chk("dig_no", {30'd0, dig_no}, {30'd0, e.no});
        chk("dig_val", {28'd0, dig_val}, {28'd0, e.val});
        chk("disp_data", {16'd0, disp_data}, {16'd0, e.disp});
        chk("dig_seen", {28'd0, dig_seen}, {28'd0, e.seen});
      end
    end
  end
  task automatic shift_bit(input logic b);
    @(negedge clk) ds_data = b;
    repeat (3) @(negedge clk);
    ds_shcp = 1'b1;
    repeat (4) @(negedge clk);
    ds_shcp = 1'b0;
    repeat (3) @(negedge clk);
  endtask
  task automatic send_bits(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) shift_bit(v[i]);
  endtask
  task automatic latch(input exp_t e);
    q.push_back(e);
    @(negedge clk) ds_stcp = 1'b1;
    repeat (4) @(negedge clk);
    ds_stcp = 1'b0;
    repeat (4) @(negedge clk);
  endtask
  task automatic chk_zero(input string nm);
    chk({nm, "_frame"}, {16'd0, frame}, 32'd0);
    chk({nm, "_disp"}, {16'd0, disp_data}, 32'd0);
    chk({nm, "_misc"}, {18'd0, frame_vld, len_err, seg_err, sel_err, dig_no, dig_val, dig_seen}, 32'd0);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    send_bits(32'hA4FB, 16);
    latch('{16'hA4FB, 1'b0, 1'b0, 1'b0, 2'd2, 4'h2, 16'h0200, 4'b0100});
    send_bits(32'h99FE, 16);
    latch('{16'h99FE, 1'b0, 1'b0, 1'b0, 2'd0, 4'h4, 16'h0204, 4'b0101});
    send_bits(32'hB0FD, 16);
    latch('{16'hB0FD, 1'b0, 1'b0, 1'b0, 2'd1, 4'h3, 16'h0234, 4'b0111});
    send_bits(32'hF9FB, 16);
    latch('{16'hF9FB, 1'b0, 1'b0, 1'b0, 2'd2, 4'h1, 16'h0134, 4'b0111});
    send_bits(32'hC0F7, 16);
    latch('{16'hC0F7, 1'b0, 1'b0, 1'b0, 2'd3, 4'h0, 16'h0134, 4'b1111});
    // 15 shifts: old bit0 of C0F7 (1) stays at [15], giving decodable C0FE but short
    send_bits(32'h40FE, 15);
    latch('{16'hC0FE, 1'b1, 1'b0, 1'b0, 2'd3, 4'h0, 16'h0134, 4'b1111});
    send_bits(32'h18EFD, 17);
    latch('{16'h8EFD, 1'b1, 1'b0, 1'b0, 2'd3, 4'h0, 16'h0134, 4'b1111});
    send_bits(32'hFFFE, 16);
    latch('{16'hFFFE, 1'b0, 1'b1, 1'b0, 2'd3, 4'h0, 16'h0134, 4'b1111});
    send_bits(32'hC0FC, 16);
    latch('{16'hC0FC, 1'b0, 1'b0, 1'b1, 2'd3, 4'h0, 16'h0134, 4'b1111});
    send_bits(32'h8EFE, 16);
    latch('{16'h8EFE, 1'b0, 1'b0, 1'b0, 2'd0, 4'hF, 16'h013F, 4'b1111});
    // shift and latch together: frame gets pre-shift bits, shifted-in 1 starts next frame
    send_bits(32'h92F7, 16);
    q.push_back('{16'h92F7, 1'b0, 1'b0, 1'b0, 2'd3, 4'h5, 16'h513F, 4'b1111});
    @(negedge clk) ds_data = 1'b1;
    repeat (3) @(negedge clk);
    ds_shcp = 1'b1;
    ds_stcp = 1'b1;
    repeat (4) @(negedge clk);
    ds_shcp = 1'b0;
    ds_stcp = 1'b0;
    repeat (4) @(negedge clk);
    send_bits(32'h21FB, 15);
    latch('{16'hA1FB, 1'b0, 1'b0, 1'b0, 2'd2, 4'hD, 16'h5D3F, 4'b1111});
    send_bits(32'hFF, 8);
    @(negedge clk) rst_n = 1'b0;
    @(negedge clk);
    chk_zero("midreset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("no_vld_after_reset", n_vld, 32'd12);
    send_bits(32'h92FD, 16);
    latch('{16'h92FD, 1'b0, 1'b0, 1'b0, 2'd1, 4'h5, 16'h0050, 4'b0010});
    repeat (10) @(negedge clk);
    chk("queue_drained", q.size(), 32'd0);
    chk("vld_pulses", n_vld, 32'd13);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/smg_595_rx.md
Name: smg_595_rx

Overview:
- Receiver/decoder for the 3-wire 74HC595 seven-segment serial link (ds_data, ds_shcp, ds_stcp) driven by the display transmitter.
- Samples the asynchronous link into clk, shifts bits on ds_shcp rising edges and latches a 16-bit frame on ds_stcp rising edges.
- Decodes each frame back into digit index and hex value, and rebuilds the 16-bit displayed word.
- Used as a loopback checker and as a snooper on the display bus.

Parameters:
SYNC_STAGES, 2, synchronizer flops per link input (legal range 2..4).
FRAME_BITS, 16, shift clocks expected per frame; fixed at 16 for the decode below.

Ports:
clk  input  1  system clock
rst_n  input  1  reset, asynchronous, active-low
ds_data  input  1  serial data, asynchronous to clk
ds_shcp  input  1  shift clock, asynchronous to clk
ds_stcp  input  1  storage/latch clock, asynchronous to clk
frame  output  16  last latched raw frame, first-shifted bit at [15]
frame_vld  output  1  1-clk pulse when frame/status update
dig_no  output  2  decoded digit index of last good frame
dig_val  output  4  decoded hex value of last good frame
len_err  output  1  bit count at latch != FRAME_BITS; valid with frame_vld
seg_err  output  1  segment byte not in code table; valid with frame_vld
sel_err  output  1  select byte not a legal one-hot pattern; valid with frame_vld
disp_data  output  16  rebuilt display word: digit k at [4k+3:4k]
dig_seen  output  4  sticky, bit k set after first good frame for digit k

Behaviour:
- Reset: all outputs 0; synchronizers, shift register and bit counter cleared. Reset mid-frame discards the partial frame; no frame_vld follows until a fresh ds_stcp rise.
- Sync: each of the three inputs goes through SYNC_STAGES flops plus one history flop. rise = sync_last & ~history. The bench holds every input level at least 3 clk.
- Shift: on a shcp rise, shreg <= {shreg[14:0], data_sync}, where data_sync is taken from the same stage depth as shcp. bit_cnt increments and saturates at 31.
- Latch: on an stcp rise, frame <= shreg, frame_vld = 1 for exactly 1 clk, and bit_cnt <= 0.
- Latency: frame_vld is high in the cycle after the clk edge where the stcp rise is detected, i.e. SYNC_STAGES+1 clk edges after the input edge is first sampled.
- Simultaneous shcp and stcp rise in the same clk:
  - frame takes the pre-shift shreg (595 behaviour).
  - The shift still occurs.
  - bit_cnt <= 1.
  - len_err is evaluated against the pre-shift count.
- Frame format:
  - frame[15:8] is the active-low segment code {dp,g,f,e,d,c,b,a}.
  - frame[7:0] is the active-low digit select.
- Segment table (hex value -> code): 0 C0, 1 F9, 2 A4, 3 B0, 4 99, 5 92, 6 82, 7 F8, 8 80, 9 90, A 88, B 83, C C6, D A1, E 86, F 8E. Any other byte sets seg_err.
- Select table: 8'hFE -> digit 0, 8'hFD -> digit 1, 8'hFB -> digit 2, 8'hF7 -> digit 3. Any other byte, including several digits active, sets sel_err.
- Error flags: len_err, seg_err and sel_err are registered together with frame and frame_vld. They hold until the next latch and are cleared on the next latch if that frame is clean.
- Good frame (all three flags 0), updated on the same edge as frame:
  - dig_no and dig_val are updated.
  - disp_data nibble dig_no <= dig_val.
  - dig_seen[dig_no] <= 1.
- Bad frame: frame and the flags update; dig_no, dig_val, disp_data and dig_seen hold.
- An stcp rise with zero shifts latches the current shreg and sets len_err.
- Bits beyond 16 shift out the MSB, so frame holds the last 16 bits received.

Test Plan:
- Reset, then frame 0xA4FB (16 shifts, 1 latch) -> frame_vld 1 clk, frame=0xA4FB, dig_no=2, dig_val=2, disp_data=0x0200, dig_seen=4'b0100, all errors 0.
- Send four frames: 0x99FE, 0xB0FD, 0xF9FB, 0xC0F7 -> disp_data=0x0134, dig_seen=4'hF, exactly four frame_vld pulses.
- 15 shifts then latch, and separately 17 shifts then latch -> len_err=1 for both, disp_data unchanged. The 17-shift case gives frame equal to the last 16 bits sent.
- Frame 0xFFFE -> seg_err=1. Frame 0xC0FC -> sel_err=1. In both cases dig_val and disp_data hold. A following clean 0x8EFE clears the flags and gives dig_val=F.
- shcp and stcp rise in the same clk after 16 good shifts -> frame equals the 16 pre-shift bits, no len_err. The next latch after 15 further shifts gives len_err=0 (count 16).
- rst_n pulsed low after 8 shifts -> all outputs 0. A following full 0x92FD frame decodes to dig_no=1, dig_val=5 with no stale bits.
